mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter on the processor data-memory port, in parallel with RAM.
//  Decodes two word addresses above the 12-bit RAM window:
//   - TX_ADDR: store pushes a byte into a TX FIFO.
//   - STAT_ADDR: load returns status.
//  Top-level muxes q_mmio onto the processor's q_dmem when mmio_hit=1.
//  Serialises FIFO bytes as 8N1 frames on uart_tx; gives test programs console output.
// PARAMETERS
//  CLKS_PER_BIT  868           clock cycles per serial bit (100 MHz / 115200); legal >= 2
//  FIFO_DEPTH    16            TX FIFO entries; power of 2, >= 2
//  TX_ADDR       32'h0000_1000 store target for TX bytes
//  STAT_ADDR     32'h0000_1004 status read / overflow-clear address
// PORTS
//  clock         in   1   system clock, all state on rising edge
//  reset         in   1   asynchronous, active-low reset
//  wren          in   1   processor store strobe (same signal that drives RAM wEn)
//  address_dmem  in   32  processor data address
//  data          in   32  processor store data; only [7:0] used for TX, [2] for status clear
//  access_type   in   3   processor access size; ignored (any size store to TX_ADDR pushes data[7:0])
//  q_mmio        out  32  registered read data for STAT_ADDR
//  mmio_hit      out  1   registered: previous-cycle address was TX_ADDR or STAT_ADDR
//  uart_tx       out  1   serial line, idle high
//  tx_busy       out  1   FSM not IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset (reset=0, async): uart_tx=1, FIFO empty (count=0, ptrs=0), overflow=0, FSM=IDLE,
//   baud/bit counters=0, q_mmio=0, mmio_hit=0, tx_busy=0.
//   Mid-frame reset aborts the frame immediately and discards FIFO contents.
//  Read path, 1-cycle latency (matches synchronous RAM):
//   - each edge: mmio_hit <= (addr==TX_ADDR || addr==STAT_ADDR).
//   - q_mmio <= (addr==STAT_ADDR) ? {28'b0, overflow, tx_busy, full, empty} : 0.
//   - Status sampled from pre-edge state.
//  Push: wren && addr==TX_ADDR. Accepted iff !full || pop in same cycle; count updates net.
//   - Rejected push: byte dropped; overflow<=1 (sticky).
//  Overflow clear: wren && addr==STAT_ADDR && data[2]==1. If a rejected push coincides, set wins.
//  Addresses other than TX_ADDR/STAT_ADDR: no state change; mmio_hit=0 next cycle.
//  FIFO: circular; rd/wr pointers wrap at FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1;
//   full = count==FIFO_DEPTH, empty = count==0.
//  FSM states IDLE, START, DATA, STOP; baud counter counts CLKS_PER_BIT-1 down to 0.
//   - IDLE: uart_tx=1. If !empty: pop into shift reg, load baud counter -> START.
//   - START: uart_tx=0 for CLKS_PER_BIT cycles -> DATA, bit index=0.
//   - DATA: uart_tx=shift[0], LSB first, CLKS_PER_BIT cycles per bit; shift right after each.
//     After bit 7 -> STOP.
//   - STOP: uart_tx=1 for CLKS_PER_BIT cycles. At end: if !empty, pop and go directly to START
//     (no idle gap); else -> IDLE.
//   - Frame is exactly 10*CLKS_PER_BIT cycles.
//  Latency: push at edge N into empty FIFO while IDLE -> pop at edge N+1 -> uart_tx=0 after edge N+1.
//  uart_tx is registered (no glitches).
// TESTING  (CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1. Reset:
//     - hold reset=0, release; read STAT_ADDR -> q_mmio=32'h1, mmio_hit=1 next cycle; uart_tx=1.
//  2. Single byte:
//     - store 32'hFFFF_FFA5 to TX_ADDR at edge N; uart_tx low from edge N+1.
//     - Bits: 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 total).
//     - Then IDLE, tx_busy=0.
//  3. Overflow:
//     - stores 0x41..0x46 on 6 consecutive edges; 0x41 popped at 2nd edge; 0x46 dropped.
//     - Status bit3=1 and bit1 (full)=1.
//     - Line carries 0x41..0x45 back-to-back: 200 cycles, no idle between frames.
//  4. Status during frame:
//     - read STAT_ADDR mid-frame with FIFO empty -> q_mmio=32'h5 (busy, empty).
//     - Read 0x1000 -> q_mmio=0, mmio_hit=1. Read 0x0004 -> mmio_hit=0.
//  5. Overflow clear:
//     - after test 3, store 32'h4 to STAT_ADDR -> bit3 clears next cycle.
//     - Clear coincident with rejected push -> bit3 stays 1.
//  6. Reset mid-frame:
//     - assert reset during DATA bit 3 with 2 bytes queued -> uart_tx=1 immediately.
//     - After release: status=32'h1, no further frames.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, sitting beside RAM on the data port.
// A store to TX_ADDR queues data[7:0]; a load from STAT_ADDR returns
// {overflow, busy, full, empty}. The read data and hit flag are registered so they line up
// with the synchronous RAM read.
module mmio_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [31:0] TX_ADDR      = 32'h0000_1000,
    parameter logic [31:0] STAT_ADDR    = 32'h0000_1004
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic [2:0]  access_type,
    output logic [31:0] q_mmio,
    output logic        mmio_hit,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudLoad = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              ovf_q, ovf_d;

    logic [31:0]       q_mmio_q, q_mmio_d;
    logic              hit_q, hit_d;

    logic              is_tx, is_stat;
    logic              full, empty, busy;
    logic              pop, push_req, push_ok, push_rej, ovf_clr;

    // Size is irrelevant: every store to TX_ADDR pushes the low byte.
    logic              unused_inputs;
    assign unused_inputs = ^{access_type, data[31:8]};

    assign is_tx    = (address_dmem == TX_ADDR);
    assign is_stat  = (address_dmem == STAT_ADDR);
    assign full     = (count_q == CntFull);
    assign empty    = (count_q == '0);
    assign busy     = (state_q != StIdle) || !empty;

    // A push into a full FIFO is still accepted when the FSM frees a slot on the same edge.
    assign push_req = wren && is_tx;
    assign push_ok  = push_req && (!full || pop);
    assign push_rej = push_req && !push_ok;
    assign ovf_clr  = wren && is_stat && data[2];

    // FIFO pointers, occupancy and sticky overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (ovf_clr)  ovf_d = 1'b0;
        // Set wins over a coincident clear.
        if (push_rej) ovf_d = 1'b1;
    end

    // Registered read path; status reflects state before this edge.
    always_comb begin
        hit_d    = is_tx || is_stat;
        q_mmio_d = is_stat ? {28'b0, ovf_q, busy, full, empty} : 32'b0;
    end

    // FIFO storage; contents need no reset since count/pointers qualify them.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= data[7:0];
    end

    // FIFO control, overflow flag and MMIO read registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            hit_q    <= 1'b0;
            q_mmio_q <= 32'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            hit_q    <= hit_d;
            q_mmio_q <= q_mmio_d;
        end
    end

    // Transmitter state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // Transmitter next state; STOP chains straight into START when more bytes are queued.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = BaudLoad;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_q == '0) begin
                    baud_d    = BaudLoad;
                    bit_idx_d = 3'd0;
                    state_d   = StData;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            StData: begin
                if (baud_q == '0) begin
                    baud_d  = BaudLoad;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            StStop: begin
                if (baud_q == '0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        baud_d  = BaudLoad;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level for the upcoming state, so uart_tx comes straight from a flop.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign uart_tx  = tx_q;
    assign tx_busy  = busy;
    assign q_mmio   = q_mmio_q;
    assign mmio_hit = hit_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed scenarios followed by random MMIO traffic,
// compared every cycle against a frame-level model (byte queue plus frame timer).
module tb_mmio_uart_tx;

    localparam int unsigned Cpb     = 4;
    localparam int unsigned Depth   = 4;
    localparam logic [31:0] TxAddr  = 32'h0000_1000;
    localparam logic [31:0] StatAddr = 32'h0000_1004;
    localparam int FrameLen = 10 * Cpb;

    logic        clock;
    logic        reset;
    logic        wren;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic [2:0]  access_type;
    logic [31:0] q_mmio;
    logic        mmio_hit;
    logic        uart_tx;
    logic        tx_busy;

    mmio_uart_tx #(
        .CLKS_PER_BIT(Cpb),
        .FIFO_DEPTH  (Depth),
        .TX_ADDR     (TxAddr),
        .STAT_ADDR   (StatAddr)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wren        (wren),
        .address_dmem(address_dmem),
        .data        (data),
        .access_type (access_type),
        .q_mmio      (q_mmio),
        .mmio_hit    (mmio_hit),
        .uart_tx     (uart_tx),
        .tx_busy     (tx_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queued bytes, sticky overflow, and the frame currently on the line.
    logic [7:0]  mq [$];
    logic        m_ovf;
    logic        m_active;
    int          m_cyc;
    logic [7:0]  m_byte;
    logic [31:0] exp_q;
    logic        exp_hit;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line level of a frame: start bit, eight data bits LSB first, stop bit.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    function automatic logic exp_tx();
        return m_active ? frame_bit(m_byte, m_cyc / Cpb) : 1'b1;
    endfunction

    function automatic logic exp_busy();
        return m_active || (mq.size() > 0);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf    = 1'b0;
        m_active = 1'b0;
        m_cyc    = 0;
        m_byte   = 8'h00;
        exp_q    = 32'h0;
        exp_hit  = 1'b0;
    endtask

    task automatic model_edge(input logic w, input logic [31:0] a, input logic [31:0] d);
        int   sz;
        logic pre_full, pre_empty, last, pop, preq, acc, rej, clr;
        sz        = mq.size();
        pre_full  = (sz == Depth);
        pre_empty = (sz == 0);
        exp_hit   = (a == TxAddr) || (a == StatAddr);
        exp_q     = (a == StatAddr) ? {28'b0, m_ovf, exp_busy(), pre_full, pre_empty} : 32'h0;
        last      = m_active && (m_cyc == FrameLen - 1);
        pop       = !pre_empty && (!m_active || last);
        preq      = w && (a == TxAddr);
        acc       = preq && (!pre_full || pop);
        rej       = preq && !acc;
        clr       = w && (a == StatAddr) && d[2];
        if (pop) begin
            m_byte   = mq.pop_front();
            m_active = 1'b1;
            m_cyc    = 0;
        end else if (last) begin
            m_active = 1'b0;
        end else if (m_active) begin
            m_cyc++;
        end
        if (acc) mq.push_back(d[7:0]);
        if (clr) m_ovf = 1'b0;
        if (rej) m_ovf = 1'b1;
    endtask

    // One clock: drive inputs, advance DUT and model on the edge, compare on the falling edge.
    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d);
        wren         = w;
        address_dmem = a;
        data         = d;
        access_type  = 3'($urandom_range(0, 7));
        @(posedge clock);
        model_edge(w, a, d);
        @(negedge clock);
        check_eq("uart_tx", 32'(uart_tx), 32'(exp_tx()));
        check_eq("tx_busy", 32'(tx_busy), 32'(exp_busy()));
        check_eq("mmio_hit", 32'(mmio_hit), 32'(exp_hit));
        check_eq("q_mmio", q_mmio, exp_q);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0000_0010, 32'h0);
    endtask

    // Asynchronous reset asserted between edges; outputs must react without a clock.
    task automatic apply_reset();
        wren  = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        check_eq("rst_uart_tx", 32'(uart_tx), 32'h1);
        check_eq("rst_tx_busy", 32'(tx_busy), 32'h0);
        check_eq("rst_q_mmio", q_mmio, 32'h0);
        check_eq("rst_mmio_hit", 32'(mmio_hit), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    logic [9:0] a5_seq;
    int         r;

    initial begin
        reset        = 1'b0;
        wren         = 1'b0;
        address_dmem = 32'h0;
        data         = 32'h0;
        access_type  = 3'd0;
        a5_seq       = 10'b11_0100_1010;
        @(negedge clock);
        apply_reset();

        // Reset state seen through the status register.
        step(1'b0, StatAddr, 32'h0);
        check_eq("reset_status", q_mmio, 32'h1);
        check_eq("reset_hit", 32'(mmio_hit), 32'h1);
        check_eq("reset_line", 32'(uart_tx), 32'h1);

        // Single byte 0xA5: line goes low one edge after the store.
        step(1'b1, TxAddr, 32'hFFFF_FFA5);
        check_eq("a5_pre_start", 32'(uart_tx), 32'h1);
        for (int i = 0; i < FrameLen; i++) begin
            step(1'b0, 32'h0000_0020, 32'h0);
            check_eq("a5_bit", 32'(uart_tx), 32'(a5_seq[i / Cpb]));
        end
        step(1'b0, 32'h0000_0020, 32'h0);
        check_eq("a5_done_busy", 32'(tx_busy), 32'h0);

        // Overflow: six back-to-back stores into a four-entry FIFO.
        for (int i = 0; i < 6; i++) step(1'b1, TxAddr, 32'h41 + 32'(i));
        step(1'b0, StatAddr, 32'h0);
        check_eq("ovf_bit3", 32'(q_mmio[3]), 32'h1);
        check_eq("ovf_full_bit1", 32'(q_mmio[1]), 32'h1);
        idle(5 * FrameLen + 5);
        check_eq("ovf_drained", 32'(tx_busy), 32'h0);

        // Overflow clear needs data[2]; other bits do not clear it.
        step(1'b1, StatAddr, 32'hFFFF_FFFB);
        step(1'b0, StatAddr, 32'h0);
        check_eq("ovf_kept", 32'(q_mmio[3]), 32'h1);
        step(1'b1, StatAddr, 32'h4);
        step(1'b0, StatAddr, 32'h0);
        check_eq("ovf_cleared", q_mmio, 32'h1);

        // Status mid-frame with the FIFO empty, then decode of the other addresses.
        step(1'b1, TxAddr, 32'h3C);
        idle(10);
        step(1'b0, StatAddr, 32'h0);
        check_eq("midframe_status", q_mmio, 32'h5);
        step(1'b0, TxAddr, 32'h0);
        check_eq("txaddr_read_q", q_mmio, 32'h0);
        check_eq("txaddr_read_hit", 32'(mmio_hit), 32'h1);
        step(1'b0, 32'h0000_0004, 32'h0);
        check_eq("ram_read_hit", 32'(mmio_hit), 32'h0);
        idle(FrameLen);

        // Reset during data bit 3 with two bytes still queued.
        step(1'b1, TxAddr, 32'h0F);
        step(1'b1, TxAddr, 32'h12);
        step(1'b1, TxAddr, 32'h34);
        for (int i = 0; i < FrameLen && !(m_active && m_cyc >= 4 * Cpb + 1); i++) idle(1);
        check_eq("pre_reset_busy", 32'(tx_busy), 32'h1);
        apply_reset();
        step(1'b0, StatAddr, 32'h0);
        check_eq("post_reset_status", q_mmio, 32'h1);
        for (int i = 0; i < 2 * FrameLen; i++) begin
            step(1'b0, 32'h0000_0100, 32'h0);
            check_eq("post_reset_quiet", 32'(uart_tx), 32'h1);
        end

        // Random traffic, with occasional bursts and one mid-run reset.
        for (int n = 0; n < 4000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                for (int k = 0; k < 6; k++) step(1'b1, TxAddr, $urandom);
            end else if (r < 9) begin
                step(1'b1, TxAddr, $urandom);
            end else if (r < 20) begin
                step(1'b0, StatAddr, $urandom);
            end else if (r < 24) begin
                step(1'b1, StatAddr, $urandom);
            end else if (r < 30) begin
                step(1'($urandom_range(0, 1)), $urandom, $urandom);
            end else begin
                step(1'b0, 32'($urandom_range(0, 4095)), $urandom);
            end
            if (n == 2000) apply_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
